// File: rtl/traffic_light_controller.sv
// Fixed-time two-way intersection controller: a Moore FSM stepping through
// NS green/yellow, all-red, EW green/yellow, all-red, with a phase counter.
module traffic_light_controller #(
  parameter int GREEN_CYCLES   = 5,
  parameter int YELLOW_CYCLES  = 2,
  parameter int ALL_RED_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_1 = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_2 = 3'd5
  } state_e;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  localparam bit         SKIP_ALL_RED = (ALL_RED_CYCLES == 0);
  localparam logic [7:0] GREEN_LAST   = 8'(GREEN_CYCLES - 1);
  localparam logic [7:0] YELLOW_LAST  = 8'(YELLOW_CYCLES - 1);
  // An all-red state reached only through illegal-state recovery still
  // lasts one cycle when the clearance phase is configured away.
  localparam logic [7:0] ALL_RED_LAST = SKIP_ALL_RED ? 8'd0 : 8'(ALL_RED_CYCLES - 1);

  if (GREEN_CYCLES < 1 || GREEN_CYCLES > 255) begin : g_bad_green
    $fatal(1, "traffic_light_controller: GREEN_CYCLES=%0d outside 1..255", GREEN_CYCLES);
  end
  if (YELLOW_CYCLES < 1 || YELLOW_CYCLES > 255) begin : g_bad_yellow
    $fatal(1, "traffic_light_controller: YELLOW_CYCLES=%0d outside 1..255", YELLOW_CYCLES);
  end
  if (ALL_RED_CYCLES < 0 || ALL_RED_CYCLES > 255) begin : g_bad_all_red
    $fatal(1, "traffic_light_controller: ALL_RED_CYCLES=%0d outside 0..255", ALL_RED_CYCLES);
  end

  logic [2:0] state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [2:0] advance_state;
  logic [7:0] last_count;
  logic       illegal_state;

  always_comb begin
    advance_state = ALL_RED_2;
    last_count    = ALL_RED_LAST;
    illegal_state = 1'b0;
    case (state_q)
      NS_GREEN: begin
        advance_state = NS_YELLOW;
        last_count    = GREEN_LAST;
      end
      NS_YELLOW: begin
        advance_state = SKIP_ALL_RED ? EW_GREEN : ALL_RED_1;
        last_count    = YELLOW_LAST;
      end
      ALL_RED_1: begin
        advance_state = EW_GREEN;
        last_count    = ALL_RED_LAST;
      end
      EW_GREEN: begin
        advance_state = EW_YELLOW;
        last_count    = GREEN_LAST;
      end
      EW_YELLOW: begin
        advance_state = SKIP_ALL_RED ? NS_GREEN : ALL_RED_2;
        last_count    = YELLOW_LAST;
      end
      ALL_RED_2: begin
        advance_state = NS_GREEN;
        last_count    = ALL_RED_LAST;
      end
      default: begin
        illegal_state = 1'b1;
      end
    endcase

    // Unused encodings fall into the second clearance phase, which leads to NS green.
    if (illegal_state) begin
      state_d = ALL_RED_2;
      count_d = 8'd0;
    end else if (count_q == last_count) begin
      state_d = advance_state;
      count_d = 8'd0;
    end else begin
      state_d = state_q;
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= NS_GREEN;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    ns_light = LAMP_RED;
    ew_light = LAMP_RED;
    case (state_q)
      NS_GREEN:  ns_light = LAMP_GREEN;
      NS_YELLOW: ns_light = LAMP_YELLOW;
      EW_GREEN:  ew_light = LAMP_GREEN;
      EW_YELLOW: ew_light = LAMP_YELLOW;
      default: begin
        ns_light = LAMP_RED;
        ew_light = LAMP_RED;
      end
    endcase
  end

  // Lamp safety properties; ignored by synthesis.
  a_red_present: assert property (@(posedge clk) ns_light[2] || ew_light[2]);
  a_one_hot: assert property (@(posedge clk) $onehot(ns_light) && $onehot(ew_light));
  a_ns_green_exit: assert property (@(posedge clk) disable iff (reset)
    ns_light == LAMP_GREEN |=> (ns_light == LAMP_GREEN || ns_light == LAMP_YELLOW));
  a_ew_green_exit: assert property (@(posedge clk) disable iff (reset)
    ew_light == LAMP_GREEN |=> (ew_light == LAMP_GREEN || ew_light == LAMP_YELLOW));

endmodule

// File: tb/tb_traffic_light_controller.sv
// Self-checking bench for traffic_light_controller: vector table, hand-written
// corner sequences, and randomized reset traffic against a phase-arithmetic model.
module tb_traffic_light_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] nsLight, ewLight;
  logic [2:0] nsSkip, ewSkip;

  int checkCount = 0;
  int passCount  = 0;
  int pos        = 0;

  bit         monOn = 1'b0;
  logic       rstAtEdge = 1'b1;
  logic [2:0] prevNs = 3'b000, prevEw = 3'b000;
  logic [2:0] prevNsS = 3'b000, prevEwS = 3'b000;

  typedef struct {
    logic       rst;
    logic [2:0] ns;
    logic [2:0] ew;
  } vec_t;

  vec_t vecQ[$];
  logic [5:0] skipSeq[8];

  traffic_light_controller dut (
    .clk      (clk),
    .reset    (reset),
    .ns_light (nsLight),
    .ew_light (ewLight)
  );

  traffic_light_controller #(
    .GREEN_CYCLES   (3),
    .YELLOW_CYCLES  (1),
    .ALL_RED_CYCLES (0)
  ) dutSkip (
    .clk      (clk),
    .reset    (reset),
    .ns_light (nsSkip),
    .ew_light (ewSkip)
  );

  always #5 clk = ~clk;

  // Lamps shown after p non-reset edges since reset, from the phase table.
  function automatic logic [5:0] modelLights(int p, int g, int y, int r);
    int m;
    m = p % (2 * (g + y + r));
    if (m < g) return {3'b001, 3'b100};
    m = m - g;
    if (m < y) return {3'b010, 3'b100};
    m = m - y;
    if (m < r) return {3'b100, 3'b100};
    m = m - r;
    if (m < g) return {3'b100, 3'b001};
    m = m - g;
    if (m < y) return {3'b100, 3'b010};
    return {3'b100, 3'b100};
  endfunction

  task automatic applyStimulus(input logic rst);
    reset = rst;
    @(posedge clk);
    #1;
    if (rst) pos = 0;
    else pos = pos + 1;
  endtask

  task automatic checkOutput(input string name, input logic [5:0] act, input logic [5:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got ns=%b ew=%b, expected ns=%b ew=%b",
                  name, act[5:3], act[2:0], exp[5:3], exp[2:0]);
  endtask

  task automatic safetyCheck(input string name, input logic [2:0] ns, input logic [2:0] ew,
                             input logic [2:0] pNs, input logic [2:0] pEw);
    bit ok;
    ok = $onehot(ns) && $onehot(ew) && (ns[2] || ew[2]);
    if (!rstAtEdge && pNs == 3'b001 && ns != 3'b001 && ns != 3'b010) ok = 1'b0;
    if (!rstAtEdge && pEw == 3'b001 && ew != 3'b001 && ew != 3'b010) ok = 1'b0;
    checkCount++;
    if (ok) passCount++;
    else $display("[TB] FAIL safety_%s: got ns=%b ew=%b after ns=%b ew=%b, expected one-hot, a red side, yellow after green",
                  name, ns, ew, pNs, pEw);
  endtask

  always @(posedge clk) rstAtEdge <= reset;

  always @(negedge clk) begin
    if (monOn) begin
      safetyCheck("main", nsLight, ewLight, prevNs, prevEw);
      safetyCheck("skip", nsSkip, ewSkip, prevNsS, prevEwS);
    end
    prevNs  = nsLight;
    prevEw  = ewLight;
    prevNsS = nsSkip;
    prevEwS = ewSkip;
  end

  initial begin
    // Default-timing sequence: two reset edges, then 19 running cycles.
    vecQ.push_back('{1'b1, 3'b001, 3'b100});
    vecQ.push_back('{1'b1, 3'b001, 3'b100});
    for (int i = 1; i <= 4; i++) vecQ.push_back('{1'b0, 3'b001, 3'b100});
    for (int i = 5; i <= 6; i++) vecQ.push_back('{1'b0, 3'b010, 3'b100});
    vecQ.push_back('{1'b0, 3'b100, 3'b100});
    for (int i = 8; i <= 12; i++) vecQ.push_back('{1'b0, 3'b100, 3'b001});
    for (int i = 13; i <= 14; i++) vecQ.push_back('{1'b0, 3'b100, 3'b010});
    vecQ.push_back('{1'b0, 3'b100, 3'b100});
    for (int i = 16; i <= 19; i++) vecQ.push_back('{1'b0, 3'b001, 3'b100});

    skipSeq[0] = 6'b001100; skipSeq[1] = 6'b001100; skipSeq[2] = 6'b001100;
    skipSeq[3] = 6'b010100; skipSeq[4] = 6'b100001; skipSeq[5] = 6'b100001;
    skipSeq[6] = 6'b100001; skipSeq[7] = 6'b100010;

    $display("[TB] start");
    @(posedge clk);
    #1;
    monOn = 1'b1;

    foreach (vecQ[i]) begin
      applyStimulus(vecQ[i].rst);
      checkOutput($sformatf("vec%0d", i), {nsLight, ewLight}, {vecQ[i].ns, vecQ[i].ew});
    end

    // No-clearance configuration: 8-cycle period, never all-red.
    applyStimulus(1'b1);
    for (int p = 0; p < 16; p++) begin
      checkOutput($sformatf("skip_seq%0d", p), {nsSkip, ewSkip}, skipSeq[p % 8]);
      applyStimulus(1'b0);
    end

    // Reset during the third EW green cycle restarts a full NS green.
    applyStimulus(1'b1);
    repeat (10) applyStimulus(1'b0);
    checkOutput("midrst_ew_green3", {nsLight, ewLight}, 6'b100001);
    applyStimulus(1'b1);
    checkOutput("midrst_abort", {nsLight, ewLight}, 6'b001100);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b0);
      checkOutput($sformatf("midrst_green%0d", k), {nsLight, ewLight}, 6'b001100);
    end
    applyStimulus(1'b0);
    checkOutput("midrst_yellow", {nsLight, ewLight}, 6'b010100);

    // Unused state code during the first clearance phase.
    applyStimulus(1'b1);
    repeat (7) applyStimulus(1'b0);
    checkOutput("pre_force_all_red", {nsLight, ewLight}, 6'b100100);
    force dut.state_q = 3'b110;
    #1;
    checkOutput("forced_illegal", {nsLight, ewLight}, 6'b100100);
    release dut.state_q;
    applyStimulus(1'b0);
    checkOutput("recover_all_red", {nsLight, ewLight}, 6'b100100);
    applyStimulus(1'b0);
    checkOutput("recover_ns_green0", {nsLight, ewLight}, 6'b001100);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b0);
      checkOutput($sformatf("recover_ns_green%0d", k), {nsLight, ewLight}, 6'b001100);
    end
    applyStimulus(1'b0);
    checkOutput("recover_ns_yellow", {nsLight, ewLight}, 6'b010100);

    // Random reset pulses over a long run, both configurations.
    applyStimulus(1'b1);
    for (int n = 0; n < 1000; n++) begin
      applyStimulus($urandom_range(0, 39) == 0);
      checkOutput($sformatf("rand_main%0d", n), {nsLight, ewLight}, modelLights(pos, 5, 2, 1));
      checkOutput($sformatf("rand_skip%0d", n), {nsSkip, ewSkip}, modelLights(pos, 3, 1, 0));
    end

    monOn = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
